// File: rtl/v_pkg.sv
// v_pkg: shared update-bus types and sizing constants for the list engine.
//   id_t / cmd_t / key_t / size_t : update field types
//   upd_t                         : one buffered update command
//   UPD_INGRESS_N                 : default ingress FIFO depth
package v_pkg;
   typedef logic [7:0] id_t;
   typedef enum logic [1:0] {ADD = 2'd0, DEL = 2'd1, MOD = 2'd2, CLR = 2'd3} cmd_t;
   typedef logic [15:0] key_t;
   typedef logic [15:0] size_t;
   typedef struct packed {
      id_t   prod_id;
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;
   localparam int UPD_INGRESS_N = 8;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with an explicit occupancy counter.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write din at wptr (caller guarantees not full)
//   pop, dout  : dout is the entry at rptr; pop advances rptr (caller guarantees not empty)
//   occ        : current number of stored entries
module fifo_sync #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     dout,
   output logic [$clog2(N):0] occ
);
   localparam int AW = $clog2(N);
   logic [W-1:0]  mem [N];
   logic [AW-1:0] wptr, rptr;
   assign dout = mem[rptr];
   always_ff @(posedge clk)
      if (push) mem[wptr] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/v_upd_ingress.sv
// v_upd_ingress: buffers feed-decoder update commands and issues them one per cycle to the list engine.
//   clk, rst            : clock, synchronous active-high reset
//   i_in_vld/o_in_rdy_r : upstream handshake; ready is registered
//   i_in_*              : incoming command payload
//   i_busy              : engine table initialisation in progress; holds issue
//   o_upd_*_r           : registered update bus to the engine
//   o_occ_r, o_afull_r  : occupancy and almost-full flag
//   o_err_r             : sticky flag for valid presented while not ready
module v_upd_ingress
   import v_pkg::*;
#(
   parameter int DEPTH     = UPD_INGRESS_N,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_in_vld,
   output logic                     o_in_rdy_r,
   input  id_t                      i_in_prod_id,
   input  cmd_t                     i_in_cmd,
   input  key_t                     i_in_key,
   input  size_t                    i_in_size,
   input  logic                     i_busy,
   output logic                     o_upd_vld_r,
   output id_t                      o_upd_prod_id_r,
   output cmd_t                     o_upd_cmd_r,
   output key_t                     o_upd_key_r,
   output size_t                    o_upd_size_r,
   output logic [$clog2(DEPTH):0]   o_occ_r,
   output logic                     o_afull_r,
   output logic                     o_err_r
);
   localparam int OW = $clog2(DEPTH) + 1;
   logic          push, pop;
   logic [OW-1:0] occ, occ_next;
   upd_t          din, head;
   assign push     = i_in_vld & o_in_rdy_r;
   assign pop      = !i_busy & (occ != '0);
   assign occ_next = occ + OW'(push) - OW'(pop);
   assign o_occ_r  = occ;
   assign din      = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};
   fifo_sync #(.N(DEPTH), .W($bits(upd_t))) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (din),
      .pop  (pop),
      .dout (head),
      .occ  (occ)
   );
   // Ready and almost-full look at next-cycle occupancy so an accepted push always has a slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_in_rdy_r      <= 1'b0;
         o_afull_r       <= 1'b0;
         o_err_r         <= 1'b0;
         o_upd_vld_r     <= 1'b0;
         o_upd_prod_id_r <= '0;
         o_upd_cmd_r     <= ADD;
         o_upd_key_r     <= '0;
         o_upd_size_r    <= '0;
      end else begin
         o_in_rdy_r  <= occ_next < OW'(DEPTH);
         o_afull_r   <= occ_next >= OW'(AFULL_LVL);
         o_err_r     <= o_err_r | (i_in_vld & !o_in_rdy_r);
         o_upd_vld_r <= pop;
         if (pop) begin
            o_upd_prod_id_r <= head.prod_id;
            o_upd_cmd_r     <= head.cmd;
            o_upd_key_r     <= head.key;
            o_upd_size_r    <= head.size;
         end
      end
   end
endmodule

// File: tb/tb_v_upd_ingress.sv
// tb_v_upd_ingress: directed self-checking bench for v_upd_ingress.
module tb_v_upd_ingress;
   import v_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_in_vld = 1'b0;
   logic        o_in_rdy_r;
   id_t         i_in_prod_id = '0;
   cmd_t        i_in_cmd = ADD;
   key_t        i_in_key = '0;
   size_t       i_in_size = '0;
   logic        i_busy = 1'b0;
   logic        o_upd_vld_r;
   id_t         o_upd_prod_id_r;
   cmd_t        o_upd_cmd_r;
   key_t        o_upd_key_r;
   size_t       o_upd_size_r;
   logic [3:0]  o_occ_r;
   logic        o_afull_r;
   logic        o_err_r;
   int          tests = 0;
   int          fails = 0;

   v_upd_ingress dut (
      .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .o_in_rdy_r(o_in_rdy_r),
      .i_in_prod_id(i_in_prod_id), .i_in_cmd(i_in_cmd), .i_in_key(i_in_key), .i_in_size(i_in_size),
      .i_busy(i_busy), .o_upd_vld_r(o_upd_vld_r), .o_upd_prod_id_r(o_upd_prod_id_r),
      .o_upd_cmd_r(o_upd_cmd_r), .o_upd_key_r(o_upd_key_r), .o_upd_size_r(o_upd_size_r),
      .o_occ_r(o_occ_r), .o_afull_r(o_afull_r), .o_err_r(o_err_r)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [15:0] k);
      i_in_vld     = 1'b1;
      i_in_key     = k;
      i_in_prod_id = k[7:0];
      i_in_cmd     = cmd_t'(k[1:0]);
      i_in_size    = k + 16'd1;
   endtask

   initial begin
      int sent, recv, exp_occ, issued;
      logic acc, exp_vld;
      logic [15:0] exp_key;
      // reset state
      tick(); tick();
      check("rst_rdy", 32'(o_in_rdy_r), 0);
      check("rst_vld", 32'(o_upd_vld_r), 0);
      check("rst_occ", 32'(o_occ_r), 0);
      check("rst_afull", 32'(o_afull_r), 0);
      check("rst_err", 32'(o_err_r), 0);
      check("rst_key", 32'(o_upd_key_r), 0);
      rst = 1'b0;
      tick();
      check("rdy_after_rst", 32'(o_in_rdy_r), 1);
      // single push, latency two cycles
      i_in_vld = 1'b1; i_in_prod_id = 8'd3; i_in_cmd = ADD; i_in_key = 16'h10; i_in_size = 16'd5;
      tick();
      i_in_vld = 1'b0;
      check("lat_t1_vld", 32'(o_upd_vld_r), 0);
      check("lat_t1_occ", 32'(o_occ_r), 1);
      tick();
      check("lat_t2_vld", 32'(o_upd_vld_r), 1);
      check("lat_prod", 32'(o_upd_prod_id_r), 3);
      check("lat_cmd", 32'(o_upd_cmd_r), 32'(ADD));
      check("lat_key", 32'(o_upd_key_r), 32'h10);
      check("lat_size", 32'(o_upd_size_r), 5);
      check("lat_occ0", 32'(o_occ_r), 0);
      tick();
      check("lat_t3_vld", 32'(o_upd_vld_r), 0);
      check("lat_hold_key", 32'(o_upd_key_r), 32'h10);
      // fill while busy, then drain back-to-back
      i_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(16'(16'h20 + i));
         tick();
         check("fill_afull", 32'(o_afull_r), 32'(i >= 5));
         check("fill_occ", 32'(o_occ_r), 32'(i + 1));
      end
      i_in_vld = 1'b0;
      check("full_rdy", 32'(o_in_rdy_r), 0);
      check("full_vld", 32'(o_upd_vld_r), 0);
      i_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("drain_vld", 32'(o_upd_vld_r), 1);
         check("drain_key", 32'(o_upd_key_r), 32'(16'h20 + i));
         check("drain_size", 32'(o_upd_size_r), 32'(16'h21 + i));
      end
      tick();
      check("drain_done_vld", 32'(o_upd_vld_r), 0);
      check("drain_done_rdy", 32'(o_in_rdy_r), 1);
      check("drain_done_occ", 32'(o_occ_r), 0);
      // start full, then stream 20 more pushes with busy low
      i_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(16'(16'h40 + i));
         tick();
      end
      i_in_vld = 1'b0;
      i_busy = 1'b0;
      sent = 0; recv = 0;
      for (int c = 0; c < 100 && recv < 28; c++) begin
         acc = (sent < 20) && o_in_rdy_r;
         if (acc) drive(16'(16'h50 + sent));
         else i_in_vld = 1'b0;
         tick();
         if (acc) sent++;
         if (o_upd_vld_r) begin
            exp_key = (recv < 8) ? 16'(16'h40 + recv) : 16'(16'h50 + recv - 8);
            check("stream_key", 32'(o_upd_key_r), 32'(exp_key));
            recv++;
         end
      end
      i_in_vld = 1'b0;
      check("stream_recv", 32'(recv), 28);
      check("stream_err", 32'(o_err_r), 0);
      tick();
      check("stream_occ", 32'(o_occ_r), 0);
      // overflow attempt while full and busy
      i_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(16'(16'h60 + i));
         tick();
      end
      drive(16'hEE);
      tick();
      i_in_vld = 1'b0;
      check("ovf_err", 32'(o_err_r), 1);
      check("ovf_occ", 32'(o_occ_r), 8);
      tick();
      check("ovf_err_sticky", 32'(o_err_r), 1);
      check("ovf_occ_hold", 32'(o_occ_r), 8);
      i_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("ovf_drain_key", 32'(o_upd_key_r), 32'(16'h60 + i));
      end
      tick();
      check("ovf_dropped_vld", 32'(o_upd_vld_r), 0);
      check("ovf_err_still", 32'(o_err_r), 1);
      // reset with 5 entries buffered
      i_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(16'(16'h70 + i));
         tick();
      end
      i_in_vld = 1'b0;
      check("pre_rst_occ", 32'(o_occ_r), 5);
      rst = 1'b1; i_busy = 1'b0;
      tick();
      check("mid_rst_occ", 32'(o_occ_r), 0);
      check("mid_rst_vld", 32'(o_upd_vld_r), 0);
      check("mid_rst_err", 32'(o_err_r), 0);
      check("mid_rst_rdy", 32'(o_in_rdy_r), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_vld", 32'(o_upd_vld_r), 0);
      end
      // toggled busy with 4 entries buffered
      i_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(16'(16'h80 + i));
         tick();
      end
      i_in_vld = 1'b0;
      exp_occ = 4; issued = 0;
      for (int c = 0; c < 12; c++) begin
         i_busy = c[0];
         exp_vld = !i_busy && (exp_occ > 0);
         tick();
         check("tog_vld", 32'(o_upd_vld_r), 32'(exp_vld));
         if (exp_vld) begin
            check("tog_key", 32'(o_upd_key_r), 32'(16'h80 + issued));
            issued++;
            exp_occ--;
         end
      end
      check("tog_total", 32'(issued), 4);
      check("tog_occ", 32'(o_occ_r), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
